// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding and widths.
package mul_pkg;

    localparam int MUL_W     = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/csadd32.sv
// 32-bit carry-select adder: a ripple first block followed by seven 4-bit blocks that
// precompute both carry-in cases and select on the incoming block carry.
module csadd32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int BLK = 4;
    localparam int NB  = 32 / BLK;

    logic [NB:0] blk_c;

    assign blk_c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK-1:0] a_s, b_s;
        assign a_s = a[g*BLK +: BLK];
        assign b_s = b[g*BLK +: BLK];

        if (g == 0) begin : g_ripple
            logic [BLK:0] s;
            assign s                = {1'b0, a_s} + {1'b0, b_s} + {{BLK{1'b0}}, blk_c[0]};
            assign sum[BLK-1:0]     = s[BLK-1:0];
            assign blk_c[1]         = s[BLK];
        end else begin : g_select
            logic [BLK:0] s0, s1;
            assign s0 = {1'b0, a_s} + {1'b0, b_s};
            assign s1 = {1'b0, a_s} + {1'b0, b_s} + {{BLK{1'b0}}, 1'b1};
            // Both candidate sums settle in parallel; only the select mux sits on the carry chain.
            assign sum[g*BLK +: BLK] = blk_c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
            assign blk_c[g+1]        = blk_c[g] ? s1[BLK]     : s0[BLK];
        end
    end

    assign cout = blk_c[NB];

endmodule

// File: rtl/mul32_seq.sv
// Unsigned 32x32 -> 64 shift-add multiplier: one csadd32 addition per cycle for 32 cycles,
// operands and product exchanged through valid/ready handshakes.
module mul32_seq
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MUL_W-1:0]     in_a,
    input  logic [MUL_W-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*MUL_W-1:0]   product,
    output logic                 busy
);

    mul_state_t           state_q, state_d;
    logic [MUL_W-1:0]     mcand_q, mcand_d;
    logic [MUL_W-1:0]     acc_hi_q, acc_hi_d;
    logic [MUL_W-1:0]     acc_lo_q, acc_lo_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

    logic [MUL_W-1:0]     add_b;
    logic [MUL_W-1:0]     add_sum;
    logic                 add_c;

    // Gating the multiplicand forces the carry to 0 whenever the multiplier bit is clear.
    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    csadd32 u_add (
        .a    (acc_hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_c)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = in_a;
                    acc_hi_d = '0;
                    acc_lo_d = in_b;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                {acc_hi_d, acc_lo_d} = {add_c, add_sum, acc_lo_q[MUL_W-1:1]};
                cnt_d                = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == MUL_CNT_W'(MUL_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule
